// File: rtl/register_file_2w.sv
// register_file_2w: 2-read / 2-write register file with busy scoreboard.
// Define REGFILE_BYPASS_EN for same-cycle write-to-read bypass.
module register_file_2w #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_0,
  input  logic [ADDR_W-1:0] wr_addr_0,
  input  logic [DATA_W-1:0] wr_data_0,
  input  logic              wr_en_1,
  input  logic [ADDR_W-1:0] wr_addr_1,
  input  logic [DATA_W-1:0] wr_data_1,
  input  logic [ADDR_W-1:0] rd_addr_1,
  output logic [DATA_W-1:0] rd_data_1,
  output logic              rd_busy_1,
  input  logic [ADDR_W-1:0] rd_addr_2,
  output logic [DATA_W-1:0] rd_data_2,
  output logic              rd_busy_2,
  input  logic              busy_set_en,
  input  logic [ADDR_W-1:0] busy_set_addr,
  output logic [ADDR_W:0]   busy_count
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;
  logic [ADDR_W:0]   cnt_nxt;
  logic              we0;
  logic              we1;
  logic              bs;

  function automatic logic is_zero(
    input logic [ADDR_W-1:0] a
  );
    return ZERO_REG && (a == '0);
  endfunction

  // Qualified enables; port 1 loses to port 0 on the same address
  always_comb begin
    we0 = wr_en_0 && !is_zero(wr_addr_0);
    we1 = wr_en_1 && !is_zero(wr_addr_1)
          && !(we0 && (wr_addr_1 == wr_addr_0));
    bs  = busy_set_en && !is_zero(busy_set_addr);
  end

  // Next busy vector: writes clear, a set on the same address wins
  always_comb begin
    busy_nxt = busy;
    if (we0) busy_nxt[wr_addr_0] = 1'b0;
    if (we1) busy_nxt[wr_addr_1] = 1'b0;
    if (bs)  busy_nxt[busy_set_addr] = 1'b1;
  end

  // Population count of the next busy vector
  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt_nxt = cnt_nxt + {{ADDR_W{1'b0}}, busy_nxt[i]};
    end
  end

  // Register storage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (we0) regs[wr_addr_0] <= wr_data_0;
      if (we1) regs[wr_addr_1] <= wr_data_1;
    end
  end

  // Busy scoreboard and its registered count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy       <= '0;
      busy_count <= '0;
    end else begin
      busy       <= busy_nxt;
      busy_count <= cnt_nxt;
    end
  end

  function automatic logic [DATA_W-1:0] rd_word(
    input logic [ADDR_W-1:0] a
  );
    logic [DATA_W-1:0] d;
    d = regs[a];
`ifdef REGFILE_BYPASS_EN
    // we0/we1 never hit the same address, so hits are exclusive
    unique case (1'b1)
      (we0 && wr_addr_0 == a): d = wr_data_0;
      (we1 && wr_addr_1 == a): d = wr_data_1;
      default: ;
    endcase
`endif
    if (!rst || is_zero(a)) d = '0;
    return d;
  endfunction

  function automatic logic rd_flag(
    input logic [ADDR_W-1:0] a
  );
    logic b;
    b = busy[a];
`ifdef REGFILE_BYPASS_EN
    // A bypassed write retires the producer unless a new one issues
    unique case (1'b1)
      (we0 && wr_addr_0 == a),
      (we1 && wr_addr_1 == a): b = bs && (busy_set_addr == a);
      default: ;
    endcase
`endif
    if (!rst || is_zero(a)) b = 1'b0;
    return b;
  endfunction

  // Read port 1
  always_comb begin
    rd_data_1 = rd_word(rd_addr_1);
    rd_busy_1 = rd_flag(rd_addr_1);
  end

  // Read port 2
  always_comb begin
    rd_data_2 = rd_word(rd_addr_2);
    rd_busy_2 = rd_flag(rd_addr_2);
  end

endmodule

// File: tb/tb_register_file_2w.sv
// tb_register_file_2w: directed + random bench for register_file_2w.
// Reference model holds register contents and busy flags as arrays.
module tb_register_file_2w;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int N  = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en_0 = 1'b0;
  logic [AW-1:0] wr_addr_0 = '0;
  logic [DW-1:0] wr_data_0 = '0;
  logic          wr_en_1 = 1'b0;
  logic [AW-1:0] wr_addr_1 = '0;
  logic [DW-1:0] wr_data_1 = '0;
  logic [AW-1:0] rd_addr_1 = '0;
  logic [DW-1:0] rd_data_1;
  logic          rd_busy_1;
  logic [AW-1:0] rd_addr_2 = '0;
  logic [DW-1:0] rd_data_2;
  logic          rd_busy_2;
  logic          busy_set_en = 1'b0;
  logic [AW-1:0] busy_set_addr = '0;
  logic [AW:0]   busy_count;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem [N];
  bit            busym [N];

  register_file_2w #(
    .DATA_W  (DW),
    .ADDR_W  (AW),
    .ZERO_REG(1'b1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en_0      (wr_en_0),
    .wr_addr_0    (wr_addr_0),
    .wr_data_0    (wr_data_0),
    .wr_en_1      (wr_en_1),
    .wr_addr_1    (wr_addr_1),
    .wr_data_1    (wr_data_1),
    .rd_addr_1    (rd_addr_1),
    .rd_data_1    (rd_data_1),
    .rd_busy_1    (rd_busy_1),
    .rd_addr_2    (rd_addr_2),
    .rd_data_2    (rd_data_2),
    .rd_busy_2    (rd_busy_2),
    .busy_set_en  (busy_set_en),
    .busy_set_addr(busy_set_addr),
    .busy_count   (busy_count)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] exp_data(
    input logic [AW-1:0] a
  );
    if (!rst || a == '0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (wr_en_0 && wr_addr_0 == a) return wr_data_0;
    if (wr_en_1 && wr_addr_1 == a) return wr_data_1;
`endif
    return mem[a];
  endfunction

  function automatic logic exp_busy(
    input logic [AW-1:0] a
  );
    if (!rst || a == '0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if ((wr_en_0 && wr_addr_0 == a) ||
        (wr_en_1 && wr_addr_1 == a))
      return busy_set_en && busy_set_addr == a;
`endif
    return busym[a];
  endfunction

  function automatic int exp_count();
    int s;
    s = 0;
    for (int i = 0; i < N; i++) s += int'(busym[i]);
    return s;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      mem[i]   = '0;
      busym[i] = 1'b0;
    end
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".rd1"}, 32'(rd_data_1), 32'(exp_data(rd_addr_1)));
    chk({tag, ".rd2"}, 32'(rd_data_2), 32'(exp_data(rd_addr_2)));
    chk({tag, ".bz1"}, 32'(rd_busy_1), 32'(exp_busy(rd_addr_1)));
    chk({tag, ".bz2"}, 32'(rd_busy_2), 32'(exp_busy(rd_addr_2)));
    chk({tag, ".cnt"}, 32'(busy_count), 32'(exp_count()));
  endtask

  // Advance one edge; the model applies the same edge's rules:
  // port 1 first so port 0 overwrites it, then a busy set wins.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      if (wr_en_1 && wr_addr_1 != '0) begin
        mem[wr_addr_1]   = wr_data_1;
        busym[wr_addr_1] = 1'b0;
      end
      if (wr_en_0 && wr_addr_0 != '0) begin
        mem[wr_addr_0]   = wr_data_0;
        busym[wr_addr_0] = 1'b0;
      end
      if (busy_set_en && busy_set_addr != '0)
        busym[busy_set_addr] = 1'b1;
    end
    #1;
  endtask

  task automatic idle();
    wr_en_0     = 1'b0;
    wr_en_1     = 1'b0;
    busy_set_en = 1'b0;
  endtask

  initial begin
    model_clear();

    // power-on reset
    #1 rst = 1'b0;
    #1 check_all("reset");
    chk("reset.cnt0", 32'(busy_count), 32'd0);
    #2 rst = 1'b1;

    // write r5 and mark busy, then reset mid-cycle
    wr_en_0 = 1'b1; wr_addr_0 = 4'd5; wr_data_0 = 16'hBEEF;
    busy_set_en = 1'b1; busy_set_addr = 4'd5;
    tick();
    idle();
    rd_addr_1 = 4'd5;
    #1 check_all("pre_rst");
    chk("pre_rst.beef", 32'(rd_data_1), 32'h0000BEEF);
    #2 rst = 1'b0;
    model_clear();
    #1 check_all("mid_rst");
    chk("mid_rst.r5", 32'(rd_data_1), 32'd0);
    chk("mid_rst.cnt", 32'(busy_count), 32'd0);
    #1 rst = 1'b1;
    #1 check_all("post_rst");

    // write 0x1000+i to every register, sweep both ports
    for (int i = 1; i < N; i++) begin
      wr_en_0   = 1'b1;
      wr_addr_0 = AW'(i);
      wr_data_0 = DW'(16'h1000 + i);
      tick();
    end
    idle();
    for (int i = 0; i < N; i++) begin
      rd_addr_1 = AW'(i);
      rd_addr_2 = AW'(N - 1 - i);
      #1 check_all("sweep");
      chk("sweep.lit", 32'(rd_data_1),
          (i == 0) ? 32'd0 : 32'(16'h1000 + i));
    end

    // collision on r3: port 0 wins
    wr_en_0 = 1'b1; wr_addr_0 = 4'd3; wr_data_0 = 16'hAAAA;
    wr_en_1 = 1'b1; wr_addr_1 = 4'd3; wr_data_1 = 16'h5555;
    tick();
    idle();
    rd_addr_1 = 4'd3;
    #1 check_all("collide");
    chk("collide.lit", 32'(rd_data_1), 32'h0000AAAA);

    // scoreboard
    busy_set_en = 1'b1; busy_set_addr = 4'd2;
    tick();
    idle();
    chk("sb.cnt1", 32'(busy_count), 32'd1);
    busy_set_en = 1'b1; busy_set_addr = 4'd7;
    tick();
    idle();
    rd_addr_1 = 4'd2;
    #1 chk("sb.cnt2", 32'(busy_count), 32'd2);
    chk("sb.busy_r2", 32'(rd_busy_1), 32'd1);
    check_all("sb_a");
    wr_en_1 = 1'b1; wr_addr_1 = 4'd2; wr_data_1 = 16'h2222;
    tick();
    idle();
    #1 chk("sb.clr_cnt", 32'(busy_count), 32'd1);
    chk("sb.clr_r2", 32'(rd_busy_1), 32'd0);
    busy_set_en = 1'b1; busy_set_addr = 4'd7;
    wr_en_0 = 1'b1; wr_addr_0 = 4'd7; wr_data_0 = 16'h7777;
    tick();
    idle();
    rd_addr_1 = 4'd7;
    #1 chk("sb.r7_busy", 32'(rd_busy_1), 32'd1);
    chk("sb.r7_data", 32'(rd_data_1), 32'h00007777);
    chk("sb.r7_cnt", 32'(busy_count), 32'd1);
    check_all("sb_b");

    // same-cycle write/read of r9
    rd_addr_2 = 4'd9;
    wr_en_0 = 1'b1; wr_addr_0 = 4'd9; wr_data_0 = 16'h1234;
    #1 check_all("byp_pre");
`ifdef REGFILE_BYPASS_EN
    chk("byp_pre.lit", 32'(rd_data_2), 32'h00001234);
`else
    chk("byp_pre.lit", 32'(rd_data_2), 32'h00001009);
`endif
    tick();
    idle();
    #1 chk("byp_post.lit", 32'(rd_data_2), 32'h00001234);

    // saturation
    for (int i = 1; i < N; i++) begin
      busy_set_en = 1'b1; busy_set_addr = AW'(i);
      tick();
    end
    idle();
    #1 chk("sat.cnt", 32'(busy_count), 32'd15);
    busy_set_en = 1'b1; busy_set_addr = 4'd4;
    tick();
    chk("sat.reset4", 32'(busy_count), 32'd15);
    busy_set_en = 1'b1; busy_set_addr = 4'd0;
    tick();
    idle();
    rd_addr_1 = 4'd0;
    #1 chk("sat.r0", 32'(busy_count), 32'd15);
    chk("sat.r0busy", 32'(rd_busy_1), 32'd0);
    check_all("sat");

    // randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      wr_en_0       = ($urandom_range(0, 9) < 6);
      wr_addr_0     = AW'($urandom_range(0, N - 1));
      wr_data_0     = DW'($urandom);
      wr_en_1       = ($urandom_range(0, 9) < 6);
      wr_addr_1     = AW'($urandom_range(0, N - 1));
      wr_data_1     = DW'($urandom);
      busy_set_en   = ($urandom_range(0, 9) < 5);
      busy_set_addr = AW'($urandom_range(0, N - 1));
      rd_addr_1     = AW'($urandom_range(0, N - 1));
      rd_addr_2     = ($urandom_range(0, 3) == 0)
                      ? wr_addr_0 : AW'($urandom_range(0, N - 1));
      #1 check_all("rnd_pre");
      tick();
      check_all("rnd_post");
    end
    idle();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
